issue_scheduler: RTL

Two-wide round-robin issue scheduler between the reservation station and the functional units. Each cycle it picks up to two ready RS entries for the two issue slots, using a rotating priority pointer so no entry starves. It also enforces occupancy of the single non-pipelined multiplier. Grants are combinational from the current requests and registered state; the pointer and multiplier occupancy are sequential.

---
 rtl/sched_pkg.sv | 24 ++
 rtl/rr_find_first.sv | 33 +++
 rtl/issue_scheduler.sv | 96 +++++++++
 3 files changed

// File: rtl/sched_pkg.sv
// Shared definitions for the two-wide round-robin issue scheduler.
package sched_pkg;

    localparam int NUM_REQ_DEF  = 8;
    localparam int MULT_LAT_DEF = 4;

    // Widest search vector the one-hot helper can encode.
    localparam int OH_MAX_W  = 64;
    localparam int OH_IDX_W  = $clog2(OH_MAX_W);

    typedef logic [$clog2(NUM_REQ_DEF)-1:0] rs_idx_t;

    // Index of the set bit in a one-hot vector (zero-extended to OH_MAX_W).
    // Returns 0 for an all-zero vector; callers qualify with a found flag.
    function automatic logic [OH_IDX_W-1:0] onehot_to_idx(input logic [OH_MAX_W-1:0] oh);
        logic [OH_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < OH_MAX_W; i++) begin
            if (oh[i]) idx = idx | OH_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_find_first.sv
// Rotating-priority find-first: first set bit of (vec & mask) at or after start,
// wrapping modulo N. N must be a power of two no wider than OH_MAX_W.
module rr_find_first
    import sched_pkg::*;
#(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  vec,
    input  logic [IW-1:0] start,
    input  logic [N-1:0]  mask,
    output logic          found,
    output logic [IW-1:0] index
);

    logic [N-1:0]   masked;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [N-1:0]   rot_oh;
    logic [IW-1:0]  rot_idx;

    // Rotate so start sits at bit 0, pick the lowest set bit, rotate the index back.
    always_comb begin
        masked  = vec & mask;
        dbl     = {masked, masked} >> start;
        rot     = dbl[N-1:0];
        rot_oh  = rot & (~rot + N'(1));
        rot_idx = IW'(onehot_to_idx(OH_MAX_W'(rot_oh)));
        found   = |rot;
        index   = rot_idx + start;
    end

endmodule

// File: rtl/issue_scheduler.sv
// Two-wide round-robin issue scheduler with single non-pipelined multiplier
// occupancy tracking. Grants are combinational; ptr and mcnt are registered.
module issue_scheduler
    import sched_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int MULT_LAT = MULT_LAT_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         is_mult,
    input  logic                       stall,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       slot0_valid,
    output logic                       slot1_valid,
    output logic [$clog2(NUM_REQ)-1:0] slot0_idx,
    output logic [$clog2(NUM_REQ)-1:0] slot1_idx,
    output logic                       mult_busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

    logic [IW-1:0]      ptr_q, ptr_d;
    logic [CW-1:0]      mcnt_q, mcnt_d;

    logic [NUM_REQ-1:0] elig;
    logic               s0_found, s1_found;
    logic [IW-1:0]      s0_idx, s1_idx;
    logic               s0_mult;
    logic [NUM_REQ-1:0] s1_mask;
    logic               mult_granted;

    assign mult_busy = (mcnt_q != '0);

    // Eligibility and the slot1 mask: drop slot0's entry, and all mults if slot0 took one.
    always_comb begin
        elig    = req & ~{NUM_REQ{stall}} & ~(is_mult & {NUM_REQ{mult_busy}});
        s0_mult = s0_found & is_mult[s0_idx];
        s1_mask = ~(NUM_REQ'(1) << s0_idx) & ~(is_mult & {NUM_REQ{s0_mult}});
    end

    rr_find_first #(.N(NUM_REQ), .IW(IW)) u_find_slot0 (
        .vec   (elig),
        .start (ptr_q),
        .mask  ({NUM_REQ{1'b1}}),
        .found (s0_found),
        .index (s0_idx)
    );

    // Starting from ptr with slot0 masked yields the next eligible entry after slot0,
    // since nothing eligible lies between ptr and slot0.
    rr_find_first #(.N(NUM_REQ), .IW(IW)) u_find_slot1 (
        .vec   (elig),
        .start (ptr_q),
        .mask  (s1_mask),
        .found (s1_found),
        .index (s1_idx)
    );

    // Output assembly: slots fill in order, invalid slots report index 0.
    always_comb begin
        slot0_valid  = s0_found;
        slot1_valid  = s0_found & s1_found;
        slot0_idx    = slot0_valid ? s0_idx : '0;
        slot1_idx    = slot1_valid ? s1_idx : '0;
        gnt          = '0;
        if (slot0_valid) gnt = gnt | (NUM_REQ'(1) << s0_idx);
        if (slot1_valid) gnt = gnt | (NUM_REQ'(1) << s1_idx);
        mult_granted = (slot0_valid & is_mult[s0_idx]) | (slot1_valid & is_mult[s1_idx]);
    end

    // Next pointer and multiplier occupancy; the counter drains even under stall.
    always_comb begin
        if (slot1_valid)      ptr_d = s1_idx + IW'(1);
        else if (slot0_valid) ptr_d = s0_idx + IW'(1);
        else                  ptr_d = ptr_q;

        mcnt_d = mcnt_q;
        if (mult_granted && (MULT_LAT > 1)) mcnt_d = CW'(MULT_LAT - 1);
        else if (mcnt_q != '0)              mcnt_d = mcnt_q - CW'(1);
    end

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q  <= '0;
            mcnt_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            mcnt_q <= mcnt_d;
        end
    end

endmodule
